// File: rtl/aes_pkg.sv
// aes_pkg: shared AES SubBytes types, constants and GF((2^4)^2) arithmetic
package aes_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam int AES_BYTES = 16;
  localparam logic [7:0] AFFINE_C = 8'h63;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;
  // GF(2^4) = GF(2)[x]/(x^4+x+1); GF(2^8)' = GF(2^4)[y]/(y^2+y+LAMBDA), byte = {hi,lo} = hi*y+lo
  localparam logic [3:0] LAMBDA = 4'hc;
  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction
  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3) ^ rotl(a, 4) ^ AFFINE_C;
  endfunction
  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ INV_AFFINE_C;
  endfunction
  // Team mux cell: its output is inverted, callers re-invert.
  function automatic logic [7:0] mux_n(input logic s, input logic [7:0] a, input logic [7:0] b);
    return ~(s ? b : a);
  endfunction
  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      p = b[i] ? p ^ t : p;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction
  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return gf4_mul(a, a);
  endfunction
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_sq(a);
    a4 = gf4_sq(a2);
    a8 = gf4_sq(a4);
    return gf4_mul(gf4_mul(a8, a4), a2);
  endfunction
  function automatic logic [7:0] gf8c_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf4_mul(a[7:4], b[7:4]);
    return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
            gf4_mul(hh, LAMBDA) ^ gf4_mul(a[3:0], b[3:0])};
  endfunction
  // (h*y+l)^-1 = (h*y + h+l) / (h^2*LAMBDA + h*l + l^2); zero maps to zero
  function automatic logic [7:0] gf8c_inv(input logic [7:0] a);
    logic [3:0] d;
    d = gf4_inv(gf4_mul(gf4_sq(a[7:4]), LAMBDA) ^ gf4_mul(a[7:4], a[3:0]) ^ gf4_sq(a[3:0]));
    return {gf4_mul(a[7:4], d), gf4_mul(a[7:4] ^ a[3:0], d)};
  endfunction
  function automatic logic [7:0] c8_pow(input logic [7:0] r, input int n);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < n; i++) p = gf8c_mul(p, r);
    return p;
  endfunction
  function automatic logic [7:0] mat_apply(input logic [63:0] cols, input logic [7:0] a);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = a[i] ? r ^ cols[8*i +: 8] : r;
    return r;
  endfunction
  // Basis change: AES x^i maps to r^i, r the first composite root of x^8+x^4+x^3+x+1.
  function automatic logic [63:0] iso_build();
    logic [63:0] cols;
    logic [7:0] r, p;
    logic found;
    cols = '0;
    found = 1'b0;
    for (int c = 2; c < 256; c++) begin
      r = 8'(c);
      p = c8_pow(r, 8) ^ c8_pow(r, 4) ^ c8_pow(r, 3) ^ r ^ 8'h01;
      if (!found && p == 8'h00) begin
        found = 1'b1;
        for (int i = 0; i < 8; i++) cols[8*i +: 8] = c8_pow(r, i);
      end
    end
    return cols;
  endfunction
  function automatic logic [63:0] iso_inv_build(input logic [63:0] iso);
    logic [63:0] cols;
    cols = '0;
    for (int j = 0; j < 8; j++)
      for (int a = 0; a < 256; a++)
        if (mat_apply(iso, 8'(a)) == 8'(1 << j)) cols[8*j +: 8] = 8'(a);
    return cols;
  endfunction
  localparam logic [63:0] ISO = iso_build();
  localparam logic [63:0] ISO_INV = iso_inv_build(ISO);
endpackage

// File: rtl/aes_subbytes_serial_if.sv
// aes_subbytes_serial_if: input/output valid-ready handshake for one AES state
interface aes_subbytes_serial_if;
  import aes_pkg::*;
  logic in_valid, in_ready, inv, out_valid, out_ready;
  logic [8*AES_BYTES-1:0] in_data, out_data;
  modport master (output in_valid, in_data, inv, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, inv, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_sbox_gf24.sv
// aes_sbox_gf24: combinational forward/inverse AES S-box via composite-field inversion
module aes_sbox_gf24
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);
  logic [7:0] pre, g;
  always_comb begin
    pre = ~mux_n(inv, din, inv_affine(din));
    g = mat_apply(ISO_INV, gf8c_inv(mat_apply(ISO, pre)));
    dout = ~mux_n(inv, affine(g), g);
  end
endmodule

// File: rtl/aes_subbytes_serial.sv
// aes_subbytes_serial: byte-serial SubBytes/InvSubBytes over a 128-bit state, one byte per cycle
module aes_subbytes_serial
  import aes_pkg::*;
#(
  parameter logic INV_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  aes_subbytes_serial_if.slave bus
);
  state_t st;
  logic [3:0] cnt;
  logic mode;
  logic [8*AES_BYTES-1:0] data;
  logic [7:0] sb_out;
  aes_sbox_gf24 u_sbox (.din(data[{cnt, 3'b000} +: 8]), .inv(mode), .dout(sb_out));
  assign bus.out_data = data;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      mode <= 1'b0;
      data <= '0;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      case (st)
        IDLE: if (bus.in_valid) begin
          st <= BUSY;
          data <= bus.in_data;
          mode <= bus.inv & INV_EN;
          cnt <= '0;
          bus.in_ready <= 1'b0;
        end
        BUSY: begin
          data[{cnt, 3'b000} +: 8] <= sb_out;
          cnt <= cnt + 4'd1;
          if (cnt == 4'(AES_BYTES - 1)) begin
            st <= DONE;
            bus.out_valid <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          st <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
